// File: rtl/icache_refill.sv
// Instruction-cache line refill engine: fetches one aligned line from a byte-wide
// RAM port, assembles it little-endian and presents it to the cache as a 1-cycle pulse.
module icache_refill #(
    parameter int BLOCK_WIDTH = 4,
    parameter int BLOCK_SIZE  = 2 ** BLOCK_WIDTH
) (
    input  logic                        clkIn,
    input  logic                        resetIn,
    input  logic                        reqValid,
    input  logic [31:0]                 reqAddr,
    input  logic                        ramGrant,
    input  logic [7:0]                  ramDataIn,
    output logic [31:0]                 ramAddr,
    output logic                        ramReadEn,
    output logic                        busy,
    output logic                        memDataValid,
    output logic [31-BLOCK_WIDTH:0]     memAddr,
    output logic [BLOCK_SIZE*8-1:0]     memDataOut
);

    localparam int LINE_W = 32 - BLOCK_WIDTH;
    localparam logic [BLOCK_WIDTH:0] SIZE_C = BLOCK_SIZE[BLOCK_WIDTH:0];
    localparam logic [BLOCK_WIDTH:0] LAST_C = SIZE_C - 1'b1;

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    state_t                    state_q, state_d;
    logic [LINE_W-1:0]         line_q, line_d;
    logic [LINE_W-1:0]         mem_addr_q, mem_addr_d;
    logic [BLOCK_WIDTH:0]      issue_cnt_q, issue_cnt_d;
    logic [BLOCK_WIDTH:0]      recv_cnt_q, recv_cnt_d;
    logic                      rd_en_q, rd_en_d;
    logic [31:0]               addr_q, addr_d;
    logic [BLOCK_SIZE*8-1:0]   line_buf_q, line_buf_d;

    // Offset bits of the request are irrelevant: refills are always line-aligned.
    logic unused_offset;
    assign unused_offset = ^reqAddr[BLOCK_WIDTH-1:0];

    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        mem_addr_d   = mem_addr_q;
        issue_cnt_d  = issue_cnt_q;
        recv_cnt_d   = recv_cnt_q;
        line_buf_d   = line_buf_q;
        ramAddr      = addr_q;
        ramReadEn    = 1'b0;
        busy         = (state_q != IDLE);
        memDataValid = (state_q == DONE);

        case (state_q)
            IDLE: begin
                if (reqValid) begin
                    line_d      = reqAddr[31:BLOCK_WIDTH];
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                if (ramGrant && (issue_cnt_q < SIZE_C)) begin
                    ramReadEn   = 1'b1;
                    ramAddr     = {line_q, issue_cnt_q[BLOCK_WIDTH-1:0]};
                    issue_cnt_d = issue_cnt_q + 1'b1;
                end
                // RAM data arrives one cycle after its address; capture ignores grant.
                if (rd_en_q) begin
                    line_buf_d[{recv_cnt_q[BLOCK_WIDTH-1:0], 3'b000} +: 8] = ramDataIn;
                    recv_cnt_d = recv_cnt_q + 1'b1;
                    if (recv_cnt_q == LAST_C) begin
                        state_d    = DONE;
                        mem_addr_d = line_q;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        rd_en_d = ramReadEn;
        addr_d  = ramAddr;
    end

    always_ff @(posedge clkIn) begin
        if (resetIn) begin
            state_q     <= IDLE;
            line_q      <= '0;
            mem_addr_q  <= '0;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            rd_en_q     <= 1'b0;
            addr_q      <= '0;
            line_buf_q  <= '0;
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            mem_addr_q  <= mem_addr_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            rd_en_q     <= rd_en_d;
            addr_q      <= addr_d;
            line_buf_q  <= line_buf_d;
        end
    end

    assign memAddr    = mem_addr_q;
    assign memDataOut = line_buf_q;

endmodule
